// File: rtl/mux_pkg.sv
// mux_pkg: shared arbitration mode type and select-width helper for arb_mux.
package mux_pkg;
  typedef enum logic {ARB_FIXED = 1'b0, ARB_RR = 1'b1} arb_mode_e;
  function automatic int sel_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/arb_mux_vc.sv
// arb_mux_vc: protocol checker bound into arb_mux when SVA_ON is defined.
`ifdef SVA_ON
module arb_mux_vc #(
  parameter int N_INPUTS = 4,
  parameter int DWIDTH   = 32,
  parameter int SEL_W    = 2
) (
  input logic                clk,
  input logic                rst,
  input logic [N_INPUTS-1:0] in_valid,
  input logic [N_INPUTS-1:0] in_ready,
  input logic                out_valid,
  input logic [DWIDTH-1:0]   out_data,
  input logic [SEL_W-1:0]    out_sel,
  input logic                out_ready
);
  a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(in_ready));
  a_valid_grant: assert property (@(posedge clk) disable iff (rst) (in_ready & ~in_valid) == '0);
  a_stable: assert property (@(posedge clk) disable iff (rst)
    out_valid && !out_ready |=> $stable(out_data) && $stable(out_sel));
endmodule

bind arb_mux arb_mux_vc #(.N_INPUTS(N_INPUTS), .DWIDTH(DWIDTH), .SEL_W(SEL_W)) u_vc (.*);
`endif

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational fixed-priority / round-robin grant via a doubled-vector scan.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  input  arb_mode_e        mode,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] idx,
  output logic             any_req
);
  logic [2*N-1:0] dbl;
  logic           found;
  int             base;
  assign dbl = {req, req};
  // Scanning the doubled vector from base wraps without needing N to be a power of two.
  always_comb begin
    grant   = '0;
    idx     = '0;
    found   = 1'b0;
    any_req = |req;
    base    = (mode == ARB_RR) ? int'(ptr) : 0;
    for (int k = 0; k < 2 * N; k++) begin
      if (!found && k >= base && dbl[k]) begin
        found          = 1'b1;
        idx            = SEL_W'(k % N);
        grant[k % N]   = 1'b1;
      end
    end
  end
endmodule

// File: rtl/arb_mux.sv
// arb_mux: N-channel valid/ready arbitrated multiplexer with one registered output stage.
module arb_mux
  import mux_pkg::*;
#(
  parameter int N_INPUTS = 4,
  parameter int DWIDTH   = 32,
  parameter int ARB_MODE = 1,
  localparam int SEL_W   = sel_width(N_INPUTS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_INPUTS-1:0] in_valid,
  input  logic [DWIDTH-1:0]   in_data [N_INPUTS],
  output logic [N_INPUTS-1:0] in_ready,
  output logic                out_valid,
  output logic [DWIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]    out_sel,
  input  logic                out_ready
);
  localparam arb_mode_e MODE = (ARB_MODE != 0) ? ARB_RR : ARB_FIXED;
  logic [N_INPUTS-1:0] grant;
  logic [SEL_W-1:0]    idx;
  logic [SEL_W-1:0]    ptr;
  logic                any_req;
  logic                accept;
  logic                take;
  rr_arbiter #(.N(N_INPUTS), .SEL_W(SEL_W)) u_arb (
    .req     (in_valid),
    .ptr     (ptr),
    .mode    (MODE),
    .grant   (grant),
    .idx     (idx),
    .any_req (any_req)
  );
  assign accept   = !out_valid | out_ready;
  assign take     = accept & any_req;
  assign in_ready = (accept && !rst) ? grant : '0;
  generate
    if (ARB_MODE != 0) begin : g_rr
      always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr <= '0;
        else if (take) ptr <= (int'(idx) == N_INPUTS - 1) ? '0 : idx + SEL_W'(1);
      end
    end else begin : g_fixed
      assign ptr = '0;
    end
  endgenerate
  // Data and select are left untouched on an idle accept; only the valid flag drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (take) begin
      out_valid <= 1'b1;
      out_data  <= in_data[idx];
      out_sel   <= idx;
    end else if (accept) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_arb_mux.sv
// tb_arb_mux: randomized check of three arb_mux configurations against a behavioural model.
module tb_arb_mux;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ordy;
  logic [3:0] vld  [3];
  logic [7:0] dat  [4];
  logic [7:0] dat3 [3];
  logic [3:0] rdy  [3];
  logic [2:0] rdy2;
  logic       ov   [3];
  logic [7:0] od   [3];
  logic [1:0] os   [3];
  int checks = 0, failures = 0;
  int n_of  [3] = '{4, 4, 3};
  bit rr_of [3] = '{1'b1, 1'b0, 1'b1};
  int m_valid [3], m_data [3], m_sel [3], m_ptr [3];
  always #5 clk = ~clk;
  assign dat3[0] = dat[0];
  assign dat3[1] = dat[1];
  assign dat3[2] = dat[2];
  assign rdy[2]  = {1'b0, rdy2};
  arb_mux #(.N_INPUTS(4), .DWIDTH(8), .ARB_MODE(1)) d0 (
    .clk(clk), .rst(rst), .in_valid(vld[0]), .in_data(dat), .in_ready(rdy[0]),
    .out_valid(ov[0]), .out_data(od[0]), .out_sel(os[0]), .out_ready(ordy));
  arb_mux #(.N_INPUTS(4), .DWIDTH(8), .ARB_MODE(0)) d1 (
    .clk(clk), .rst(rst), .in_valid(vld[1]), .in_data(dat), .in_ready(rdy[1]),
    .out_valid(ov[1]), .out_data(od[1]), .out_sel(os[1]), .out_ready(ordy));
  arb_mux #(.N_INPUTS(3), .DWIDTH(8), .ARB_MODE(1)) d2 (
    .clk(clk), .rst(rst), .in_valid(vld[2][2:0]), .in_data(dat3), .in_ready(rdy2),
    .out_valid(ov[2]), .out_data(od[2]), .out_sel(os[2]), .out_ready(ordy));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input int n, input bit rr, input int p, input logic [3:0] v);
    for (int k = 0; k < n; k++) begin
      int j = rr ? (p + k) % n : k;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_valid[d] = 0; m_data[d] = 0; m_sel[d] = 0; m_ptr[d] = 0;
    end
  endtask

  task automatic check_outputs();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("d%0d_out_valid", d), 32'(ov[d]), 32'(m_valid[d]));
      chk($sformatf("d%0d_out_data", d), 32'(od[d]), 32'(m_data[d]));
      chk($sformatf("d%0d_out_sel", d), 32'(os[d]), 32'(m_sel[d]));
    end
  endtask

  // kind: 0 random requests, 1 all valid with fixed data, 2 no requests
  task automatic cycle(input int kind, input bit rand_rdy);
    @(negedge clk);
    check_outputs();
    ordy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int i = 0; i < 4; i++) dat[i] = (kind == 1) ? 8'(8'h10 + i) : 8'($urandom);
    for (int d = 0; d < 3; d++) begin
      vld[d] = (kind == 1) ? 4'hF : (kind == 2) ? 4'h0 : 4'($urandom);
      if (d == 2) vld[d][3] = 1'b0;
    end
    #1;
    for (int d = 0; d < 3; d++) begin
      bit acc = (m_valid[d] == 0) || ordy;
      int g   = pick(n_of[d], rr_of[d], m_ptr[d], vld[d]);
      chk($sformatf("d%0d_in_ready", d), 32'(rdy[d]), (acc && g >= 0) ? 32'(1) << g : 32'(0));
      if (acc && g >= 0) begin
        m_valid[d] = 1; m_data[d] = int'(dat[g]); m_sel[d] = g;
        if (rr_of[d]) m_ptr[d] = (g == n_of[d] - 1) ? 0 : g + 1;
      end else if (acc) m_valid[d] = 0;
    end
  endtask

  task automatic reset_phase();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) vld[d] = 4'($urandom);
      for (int i = 0; i < 4; i++) dat[i] = 8'($urandom);
      #1;
      for (int d = 0; d < 3; d++) chk($sformatf("d%0d_rst_in_ready", d), 32'(rdy[d]), 32'(0));
      check_outputs();
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) vld[d] = 4'h0;
    rst = 1'b0;
  endtask

  initial begin
    ordy = 1'b1;
    for (int d = 0; d < 3; d++) vld[d] = 4'h0;
    for (int i = 0; i < 4; i++) dat[i] = 8'h0;
    model_reset();
    reset_phase();
    for (int c = 0; c < 10; c++) cycle(1, 1'b0);
    for (int c = 0; c < 400; c++) cycle(0, 1'b1);
    for (int c = 0; c < 3; c++) cycle(2, 1'b0);
    for (int c = 0; c < 200; c++) cycle($urandom_range(0, 3) == 0 ? 1 : 0, 1'b1);
    cycle(1, 1'b0);
    cycle(1, 1'b0);
    @(negedge clk);
    check_outputs();
    rst = 1'b1;
    #1;
    model_reset();
    for (int d = 0; d < 3; d++) chk($sformatf("d%0d_async_rst_valid", d), 32'(ov[d]), 32'(0));
    reset_phase();
    for (int c = 0; c < 200; c++) cycle(0, 1'b1);
    cycle(2, 1'b0);
    @(negedge clk);
    check_outputs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/arb_mux.md
Name: arb_mux

Overview:
- Parametrised successor of the combinational `mux`: an N-channel valid/ready arbitrated multiplexer with one registered output stage.
- Selects one requesting input per cycle, using either fixed-priority or round-robin arbitration, and forwards its data plus the source index downstream.
- Used wherever several pipeline producers share one consumer, e.g. register-file write-back sources or memory request ports.

Parameters:
- N_INPUTS, 4, number of input channels (>=1; need not be a power of two).
- DWIDTH, 32, data width per channel in bits.
- ARB_MODE, 1, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  N_INPUTS  per-channel request.
- in_data  input  [DWIDTH-1:0] x N_INPUTS (unpacked array)  per-channel data.
- in_ready  output  N_INPUTS  per-channel accept; one-hot or zero.
- out_valid  output  1  output register holds valid data.
- out_data  output  DWIDTH  registered selected data.
- out_sel  output  SEL_W  registered index of the granted channel; SEL_W = (N_INPUTS>1) ? $clog2(N_INPUTS) : 1.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset (async assert, sync-safe deassert) gives: out_valid=0, out_data=0, out_sel=0, round-robin pointer ptr=0.
- A reset asserted mid-stream discards any held beat. in_ready is 0 while rst=1.
- Transfer rules:
  - Input handshake on channel i: in_valid[i] & in_ready[i] on a rising edge.
  - Output handshake: out_valid & out_ready.
- accept = !out_valid | out_ready. This is combinational; it depends only on out_valid and out_ready.
- Grant g is computed combinationally from in_valid:
  - ARB_MODE=0: g = lowest index i with in_valid[i]=1.
  - ARB_MODE=1: g = first index with in_valid set, scanning ptr, ptr+1, ..., N_INPUTS-1, 0, ..., ptr-1.
- in_ready[g] = accept & |in_valid; all other bits are 0. in_ready never asserts for a channel whose in_valid=0.
- Register update on each rising edge:
  - If accept & |in_valid: out_data <= in_data[g], out_sel <= g, out_valid <= 1. In ARB_MODE=1 also ptr <= (g == N_INPUTS-1) ? 0 : g+1.
  - Else if accept (no requests): out_valid <= 0. out_data and out_sel keep their last values (don't-care for consumers). ptr unchanged.
  - Else (stall: out_valid & !out_ready): all registers hold, in_ready = 0, ptr unchanged.
- Latency: 1 cycle from input handshake to out_valid.
- Throughput: 1 beat/cycle when out_ready is held high.
- Simultaneous drain and fill is allowed: out_ready=1 and a new grant in the same cycle give a back-to-back beat with no bubble.
- Fairness: in round-robin mode, with all N channels continuously valid, each channel is granted exactly once per N accepted beats.
- ARB_MODE=0 keeps no pointer state; the ptr register is optimised away.
- N_INPUTS=1: g=0 always, out_sel=0; the block degenerates to a single pipeline register.
- Data stability: out_data and out_sel must not change while out_valid=1 and out_ready=0.
- SVA (under SVA_ON, bound checker arb_mux_vc):
  - in_ready is one-hot-or-zero.
  - out_data and out_sel are stable under stall.
  - No grant goes to a channel that is not valid.

Decomposition:
- Package mux_pkg holds:
  - function sel_width(n), returning n>1 ? $clog2(n) : 1;
  - enum arb_mode_e {ARB_FIXED=0, ARB_RR=1}.
- Sub-module rr_arbiter: purely combinational. Inputs are req[N] and ptr[SEL_W] plus a mode input; outputs are a one-hot grant[N], grant index and any_req. It uses a doubled-vector priority scan to handle wrap for non-power-of-two N.
- arb_mux owns the pointer register, the output register and the handshake logic.

Test Plan:
- Reset: hold rst=1 with random in_valid/in_data -> out_valid=0, out_data=0, out_sel=0, in_ready=0000. Assert rst mid-stream with out_valid=1 -> out_valid=0 immediately, without waiting for a clock edge.
- Single requester: N=4, DWIDTH=8, in_valid=0010, in_data[1]=8'hA5, out_ready=1 -> in_ready=0010 the same cycle; next cycle out_valid=1, out_data=8'hA5, out_sel=1.
- Round-robin fairness: ARB_MODE=1, in_valid=1111 held, out_ready=1, in_data[i]=8'h10+i -> out_sel sequence 0,1,2,3,0,1 and out_data 10,11,12,13,10,11 with no bubbles.
- Fixed priority: ARB_MODE=0, same stimulus -> out_sel=0 every beat, in_ready=0001 continuously. Then drop in_valid[0] -> out_sel=1 on the next beat.
- Backpressure: ARB_MODE=1, in_valid=1111, out_ready=0 for 3 cycles after a beat with out_sel=2 -> out_data/out_sel held, in_ready=0000, ptr stays 3. Raise out_ready -> next beats are out_sel 3, 0.
- Non-power-of-two wrap: N_INPUTS=3, grant 2 issued, then in_valid=101 -> next grant 0 (ptr wrapped to 0, not 3). With in_valid=000 and out_ready=1 -> out_valid drops to 0 next cycle.
